// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch unit
package instruction_fetch_unit_pkg;

    // Instruction word presented whenever the output slot is empty.
    localparam logic [15:0] INVALID_INSTRUCTION = 16'hFFFF;

    // First PC fetched after reset unless the instance overrides it.
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding at pc
        ST_HOLD  = 2'd1,  // skid full, no request until it drains
        ST_DRAIN = 2'd2   // waiting out a request made stale by a redirect
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and instruction fetcher feeding the IF/ID register
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   stall                      IF/ID will not capture; presented slot must hold
//   redirect_valid/redirect_pc one-cycle branch/jump redirect
//   i_readM/i_address          read request to instruction memory
//   i_data/i_ready             read response, one strobe per request
//   pc_out/instruction_out     presented {PC+1, instruction}
//   out_valid                  presented slot holds a real instruction
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        i_readM,
    output logic [15:0] i_address,
    input  logic [15:0] i_data,
    input  logic        i_ready,
    output logic [15:0] pc_out,
    output logic [15:0] instruction_out,
    output logic        out_valid
);

    fetch_state_e state_q;
    logic [15:0]  pc_q;
    logic [15:0]  drain_addr_q;
    logic         discard_q;

    logic [15:0]  slot_pc_q;
    logic [15:0]  slot_instr_q;
    logic         slot_valid_q;

    logic [15:0]  skid_pc_q;
    logic [15:0]  skid_instr_q;
    logic         skid_valid_q;

    logic [15:0]  pc_inc;
    logic         slot_free;

    assign pc_inc    = pc_q + 16'd1;
    // The slot can take new data if it is empty or IF/ID captures it at this edge.
    assign slot_free = !slot_valid_q || !stall;

    // Request is gated by reset so it is low during reset and rises the first
    // cycle reset is released. DRAIN keeps the stale address until its response.
    assign i_readM   = !reset && (state_q != ST_HOLD);
    assign i_address = reset ? 16'h0000 :
                       (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    assign pc_out          = slot_pc_q;
    assign instruction_out = slot_instr_q;
    assign out_valid       = slot_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= 16'h0000;
            discard_q    <= 1'b0;
            slot_pc_q    <= 16'h0000;
            slot_instr_q <= INVALID_INSTRUCTION;
            slot_valid_q <= 1'b0;
            skid_pc_q    <= 16'h0000;
            skid_instr_q <= INVALID_INSTRUCTION;
            skid_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q         <= redirect_pc;
            slot_pc_q    <= 16'h0000;
            slot_instr_q <= INVALID_INSTRUCTION;
            slot_valid_q <= 1'b0;
            skid_pc_q    <= 16'h0000;
            skid_instr_q <= INVALID_INSTRUCTION;
            skid_valid_q <= 1'b0;
            if (state_q != ST_HOLD && !i_ready) begin
                // A request is still open; it must be held until answered.
                state_q   <= ST_DRAIN;
                discard_q <= 1'b1;
                if (state_q == ST_FETCH) begin
                    drain_addr_q <= pc_q;
                end
            end else begin
                // Either no request is open or it completes now; drop its data.
                state_q   <= ST_FETCH;
                discard_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (i_ready && !discard_q) begin
                        pc_q <= pc_inc;
                        if (slot_free) begin
                            slot_pc_q    <= pc_inc;
                            slot_instr_q <= i_data;
                            slot_valid_q <= 1'b1;
                        end else begin
                            skid_pc_q    <= pc_inc;
                            skid_instr_q <= i_data;
                            skid_valid_q <= 1'b1;
                            state_q      <= ST_HOLD;
                        end
                    end else if (!stall) begin
                        slot_pc_q    <= 16'h0000;
                        slot_instr_q <= INVALID_INSTRUCTION;
                        slot_valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        slot_pc_q    <= skid_pc_q;
                        slot_instr_q <= skid_instr_q;
                        slot_valid_q <= skid_valid_q;
                        skid_pc_q    <= 16'h0000;
                        skid_instr_q <= INVALID_INSTRUCTION;
                        skid_valid_q <= 1'b0;
                        state_q      <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        slot_pc_q    <= 16'h0000;
                        slot_instr_q <= INVALID_INSTRUCTION;
                        slot_valid_q <= 1'b0;
                    end
                    if (i_ready) begin
                        discard_q <= 1'b0;
                        state_q   <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
